// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one shared 1-bit full adder is stepped
// LSB-first over WIDTH cycles behind a start/ready/done handshake.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic y,
  output logic co
);
  assign y  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PENULT = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             c_msb_in;
  logic             fa_y, fa_co;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .y  (fa_y),
    .co (fa_co)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Ovf      <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // Subtraction is A + ~B + 1, so the inversion and forced carry happen at accept.
          if (start) begin
            a_sh  <= A;
            b_sh  <= Sub ? ~B : B;
            carry <= Sub ? 1'b1 : Cin;
            cnt   <= '0;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end
        ADD: begin
          sum_sh <= {fa_y, sum_sh[WIDTH-1:1]};
          carry  <= fa_co;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == PENULT) c_msb_in <= fa_co;
          if (cnt == LAST) begin
            Sum  <= {fa_y, sum_sh[WIDTH-1:1]};
            Cout <= fa_co;
            Ovf  <= c_msb_in ^ fa_co;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed-vector bench for serial_adder_ctrl (WIDTH=8).

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         Sub = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         ready, busy, done, Cout, Ovf;
  logic [W-1:0] Sum;

  int vectors = 0;
  int miscompares = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Sub   (Sub),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout),
    .Ovf   (Ovf)
  );

  always #5 clk = ~clk;

  // Stimulus only: pulses start for one accept edge, then counts edges until done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       output int lat, output int busy_cnt, output logic rdy_acc,
                       output logic done_after, output logic rdy_after);
    A = a; B = b; Cin = cin; Sub = sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rdy_acc = ready;
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
      if (busy) busy_cnt++;
    end
    @(posedge clk); #1;
    done_after = done;
    rdy_after = ready;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    vectors++;
    if ({ready, busy, done, Cout, Ovf} !== 5'b10000 || Sum !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: ready/busy/done/cout/ovf=%b sum=%h, required 10000 sum=00",
               {ready, busy, done, Cout, Ovf}, Sum);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: ready=%b busy=%b, required 1 0", ready, busy);
    end
  endtask

  task automatic test_add;
    int lat, bc; logic ra, da, rdy;
    do_op(8'h3C, 8'h05, 1'b0, 1'b0, lat, bc, ra, da, rdy);
    vectors++;
    if (lat !== 8) begin miscompares++; $display("FAIL add_latency: %0d, required 8", lat); end
    vectors++;
    if (ra !== 1'b0 || bc !== 8) begin
      miscompares++;
      $display("FAIL add_busy: ready_at_accept=%b busy_cycles=%0d, required 0 8", ra, bc);
    end
    vectors++;
    if (Sum !== 8'h41 || Cout !== 1'b0 || Ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL add_result: sum=%h cout=%b ovf=%b, required 41 0 0", Sum, Cout, Ovf);
    end
    vectors++;
    if (da !== 1'b0 || rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL add_done_pulse: done=%b ready=%b after done, required 0 1", da, rdy);
    end
  endtask

  task automatic test_carry_chain;
    int lat, bc; logic ra, da, rdy;
    do_op(8'hFF, 8'h01, 1'b1, 1'b0, lat, bc, ra, da, rdy);
    vectors++;
    if (lat !== 8 || Sum !== 8'h01 || Cout !== 1'b1 || Ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL carry_chain: lat=%0d sum=%h cout=%b ovf=%b, required 8 01 1 0", lat, Sum, Cout, Ovf);
    end
  endtask

  task automatic test_overflow;
    int lat, bc; logic ra, da, rdy;
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, lat, bc, ra, da, rdy);
    vectors++;
    if (lat !== 8 || Sum !== 8'h80 || Cout !== 1'b0 || Ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL signed_ovf: lat=%0d sum=%h cout=%b ovf=%b, required 8 80 0 1", lat, Sum, Cout, Ovf);
    end
  endtask

  task automatic test_subtract;
    int lat, bc; logic ra, da, rdy;
    do_op(8'h05, 8'h07, 1'b1, 1'b1, lat, bc, ra, da, rdy);
    vectors++;
    if (lat !== 8 || Sum !== 8'hFE || Cout !== 1'b0 || Ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_borrow: lat=%0d sum=%h cout=%b ovf=%b, required 8 FE 0 0", lat, Sum, Cout, Ovf);
    end
    do_op(8'h80, 8'h01, 1'b0, 1'b1, lat, bc, ra, da, rdy);
    vectors++;
    if (lat !== 8 || Sum !== 8'h7F || Cout !== 1'b1 || Ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_ovf: lat=%0d sum=%h cout=%b ovf=%b, required 8 7F 1 1", lat, Sum, Cout, Ovf);
    end
  endtask

  task automatic test_back_to_back;
    int gap;
    int lat;
    A = 8'h10; B = 8'h20; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    A = 8'hAA; B = 8'h55;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    vectors++;
    if (lat !== 8 || Sum !== 8'h30) begin
      miscompares++;
      $display("FAIL b2b_first: lat=%0d sum=%h, required 8 30", lat, Sum);
    end
    gap = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin gap = k; break; end
    end
    start = 1'b0;
    vectors++;
    if (gap !== W + 2 || Sum !== 8'hFF || Cout !== 1'b0 || Ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: gap=%0d sum=%h cout=%b ovf=%b, required 10 FF 0 0", gap, Sum, Cout, Ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    int lat, bc; logic ra, da, rdy;
    A = 8'h33; B = 8'h44; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1 || Sum !== 8'hFF) begin
      miscompares++;
      $display("FAIL pre_reset: busy=%b sum=%h, required 1 FF", busy, Sum);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ready, busy, done, Cout, Ovf} !== 5'b10000 || Sum !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset: ready/busy/done/cout/ovf=%b sum=%h, required 10000 sum=00",
               {ready, busy, done, Cout, Ovf}, Sum);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h01, 8'h01, 1'b0, 1'b0, lat, bc, ra, da, rdy);
    vectors++;
    if (lat !== 8 || Sum !== 8'h02 || Cout !== 1'b0 || Ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_add: lat=%0d sum=%h cout=%b ovf=%b, required 8 02 0 0", lat, Sum, Cout, Ovf);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_carry_chain;
    test_overflow;
    test_subtract;
    test_back_to_back;
    test_reset_mid_op;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
